// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: size, FSM state and exception encodings,
// plus the EX/MEM and MEM/WB register layouts (fields sized for the widest XLEN).
package riscv_pkg;

  localparam int unsigned PKG_XLEN = 64;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [3:0] {
    EXC_NONE           = 4'd0,
    LOAD_MISALIGNED    = 4'd4,
    LOAD_ACCESS_FAULT  = 4'd5,
    STORE_MISALIGNED   = 4'd6,
    STORE_ACCESS_FAULT = 4'd7
  } exc_cause_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_read;
    logic      mem_write;
    mem_size_e mem_size;
    logic      mem_unsigned;
  } ctrl_t;

  typedef struct packed {
    ctrl_t                ctrl;
    logic [4:0]           rd;
    logic [PKG_XLEN-1:0]  alu_result;
    logic [PKG_XLEN-1:0]  rs2_data;
  } ex_mem_t;

  typedef struct packed {
    ctrl_t                ctrl;
    logic [4:0]           rd;
    logic [PKG_XLEN-1:0]  alu_result;
    logic [PKG_XLEN-1:0]  mem_data;
    logic                 exc_valid;
    exc_cause_e           exc_cause;
  } mem_wb_t;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    case (size)
      SIZE_B:  return 4'd1;
      SIZE_H:  return 4'd2;
      SIZE_W:  return 4'd4;
      SIZE_D:  return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment detection, store replication/strobes
// and load byte extraction with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] wstrb,
  output logic [XLEN-1:0]   load_data,
  output logic              misaligned
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  mem_size_e       size_s;
  logic [OW-1:0]   off_s;
  logic [XLEN-1:0] shifted_s;

  assign size_s    = mem_size_e'(size);
  assign off_s     = addr_lo[OW-1:0];
  assign shifted_s = rdata >> {off_s, 3'b000};

  // Offset bits below the access size must be clear; D never fits a 32-bit datapath
  always_comb begin
    misaligned = 1'b0;
    case (size_s)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = addr_lo[0];
      SIZE_W:  misaligned = |addr_lo[1:0];
      SIZE_D:  misaligned = (XLEN == 32'd32) ? 1'b1 : |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

  // Lane replication, byte strobes and load extension
  always_comb begin
    int nb;
    int off;
    logic ext_bit;
    wdata     = '0;
    wstrb     = '0;
    load_data = '0;
    nb  = (int'(size_bytes(size_s)) > int'(NB)) ? int'(NB) : int'(size_bytes(size_s));
    off = int'(off_s);
    ext_bit = ~is_unsigned & shifted_s[8*nb-1];
    for (int i = 0; i < int'(NB); i++) begin
      wdata[8*i +: 8] = store_data[8*(i % nb) +: 8];
      wstrb[i]        = (i >= off) && (i < off + nb);
    end
    for (int i = 0; i < int'(XLEN); i++) begin
      load_data[i] = (i < 8*nb) ? shifted_s[i] : ext_bit;
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM pipeline stage: drives the data-memory request handshake, stalls the pipe
// while a response is outstanding, and fills the MEM/WB register.
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  ex_mem_t           ex_mem_in,
  input  logic              stall,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_busy,
  output mem_wb_t           mem_wb_out
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e      state_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] hold_r;
  logic            done_r;
  logic            fault_r;
  logic            flushed_r;
  ctrl_t           op_ctrl_r;
  logic [4:0]      op_rd_r;
  logic [63:0]     op_addr_r;
  logic            req_we_r;
  logic [XLEN-1:0] req_addr_r;
  logic [XLEN-1:0] req_wdata_r;
  logic [NB-1:0]   req_wstrb_r;
  mem_wb_t         wb_r;

  logic            sel_idle_s;
  logic [1:0]      sel_size_s;
  logic            sel_uns_s;
  logic [2:0]      sel_addr_lo_s;
  logic            is_mem_s;
  logic            misaligned_s;
  logic            issue_s;
  logic            complete_s;
  logic            timeout_s;
  logic            busy_s;
  logic            wb_load_s;
  logic [XLEN-1:0] rd_src_s;
  logic [XLEN-1:0] align_wdata_s;
  logic [NB-1:0]   align_wstrb_s;
  logic [XLEN-1:0] load_data_s;
  mem_wb_t         wb_next_s;

  if (XLEN < 64) begin : g_narrow
    logic unused_s;
    assign unused_s = ^ex_mem_in.rs2_data[63:XLEN];
  end

  // Align logic sees the incoming op when idle, the latched op once in flight
  assign sel_idle_s    = (state_r == IDLE) && !done_r;
  assign sel_size_s    = sel_idle_s ? ex_mem_in.ctrl.mem_size : op_ctrl_r.mem_size;
  assign sel_uns_s     = sel_idle_s ? ex_mem_in.ctrl.mem_unsigned : op_ctrl_r.mem_unsigned;
  assign sel_addr_lo_s = sel_idle_s ? ex_mem_in.alu_result[2:0] : op_addr_r[2:0];

  assign is_mem_s   = ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write;
  assign issue_s    = sel_idle_s & is_mem_s & ~misaligned_s;
  assign complete_s = (state_r == RESP) & dmem_rvalid;
  assign timeout_s  = (state_r != IDLE) & (cnt_r == CNT_LAST) & ~complete_s;
  assign busy_s     = (state_r == IDLE) ? issue_s : ~(complete_s | timeout_s);
  assign wb_load_s  = ~stall & ~busy_s;
  assign rd_src_s   = complete_s ? dmem_rdata : hold_r;
  assign mem_busy   = busy_s;
  assign mem_wb_out = wb_r;

  lsu_align #(.XLEN(XLEN)) u_align (
    .size        (sel_size_s),
    .is_unsigned (sel_uns_s),
    .addr_lo     (sel_addr_lo_s),
    .store_data  (ex_mem_in.rs2_data[XLEN-1:0]),
    .rdata       (rd_src_s),
    .wdata       (align_wdata_s),
    .wstrb       (align_wstrb_s),
    .load_data   (load_data_s),
    .misaligned  (misaligned_s)
  );

  // Request drive: combinational on issue, replayed from registers while waiting for grant
  always_comb begin
    if (state_r == IDLE) begin
      dmem_req   = issue_s & rst_n;
      dmem_we    = ex_mem_in.ctrl.mem_write;
      dmem_addr  = {ex_mem_in.alu_result[XLEN-1:OW], {OW{1'b0}}};
      dmem_wdata = align_wdata_s;
      dmem_wstrb = align_wstrb_s;
    end else begin
      dmem_req   = (state_r == REQ) & rst_n;
      dmem_we    = req_we_r;
      dmem_addr  = req_addr_r;
      dmem_wdata = req_wdata_r;
      dmem_wstrb = req_wstrb_r;
    end
  end

  // Next MEM/WB contents for pass-through, misalignment, completion or fault
  always_comb begin
    wb_next_s = '0;
    if (sel_idle_s) begin
      wb_next_s.ctrl       = ex_mem_in.ctrl;
      wb_next_s.rd         = ex_mem_in.rd;
      wb_next_s.alu_result = ex_mem_in.alu_result;
      if (is_mem_s && misaligned_s) begin
        wb_next_s.ctrl.reg_write = 1'b0;
        wb_next_s.exc_valid      = 1'b1;
        wb_next_s.exc_cause      = ex_mem_in.ctrl.mem_write ? STORE_MISALIGNED : LOAD_MISALIGNED;
      end else begin
        wb_next_s.exc_valid = 1'b0;
      end
    end else if (flushed_r) begin
      wb_next_s = '0;
    end else begin
      wb_next_s.ctrl       = op_ctrl_r;
      wb_next_s.rd         = op_rd_r;
      wb_next_s.alu_result = op_addr_r;
      if (timeout_s || (done_r && fault_r)) begin
        wb_next_s.ctrl.reg_write = 1'b0;
        wb_next_s.exc_valid      = 1'b1;
        wb_next_s.exc_cause      = op_ctrl_r.mem_write ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
      end else if (op_ctrl_r.mem_read) begin
        wb_next_s.mem_data = 64'(load_data_s);
      end else begin
        wb_next_s.mem_data = 64'd0;
      end
    end
  end

  // Transaction FSM with timeout; done_r blocks a re-request while the result waits on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      hold_r      <= '0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      flushed_r   <= 1'b0;
      op_ctrl_r   <= '0;
      op_rd_r     <= 5'd0;
      op_addr_r   <= 64'd0;
      req_we_r    <= 1'b0;
      req_addr_r  <= '0;
      req_wdata_r <= '0;
      req_wstrb_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (done_r) begin
            if (flush || wb_load_s) begin
              done_r    <= 1'b0;
              fault_r   <= 1'b0;
              flushed_r <= 1'b0;
            end
          end else if (issue_s) begin
            op_ctrl_r   <= ex_mem_in.ctrl;
            op_rd_r     <= ex_mem_in.rd;
            op_addr_r   <= ex_mem_in.alu_result;
            req_we_r    <= dmem_we;
            req_addr_r  <= dmem_addr;
            req_wdata_r <= dmem_wdata;
            req_wstrb_r <= dmem_wstrb;
            flushed_r   <= flush;
            fault_r     <= 1'b0;
            state_r     <= dmem_gnt ? RESP : REQ;
          end
        end
        REQ: begin
          cnt_r     <= cnt_r + 1'b1;
          flushed_r <= flushed_r | flush;
          if (timeout_s) begin
            state_r <= IDLE;
            fault_r <= 1'b1;
            done_r  <= stall & ~flush;
          end else if (dmem_gnt) begin
            state_r <= RESP;
          end
        end
        RESP: begin
          cnt_r     <= cnt_r + 1'b1;
          flushed_r <= flushed_r | flush;
          if (complete_s) begin
            hold_r  <= dmem_rdata;
            state_r <= IDLE;
            done_r  <= stall & ~flush;
          end else if (timeout_s) begin
            state_r <= IDLE;
            fault_r <= 1'b1;
            done_r  <= stall & ~flush;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // MEM/WB register: flush bubble wins, otherwise load when neither stalled nor busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_r <= '0;
    end else if (flush) begin
      wb_r <= '0;
    end else if (wb_load_s) begin
      wb_r <= wb_next_s;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage (XLEN=32, TIMEOUT=64) with hand-computed expectations.
module tb_lsu_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  ex_mem_t     ex_mem_in;
  logic        stall, flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_busy;
  mem_wb_t     mem_wb_out;

  int n_checks = 0;
  int n_errors = 0;
  int busy_n, req_n;

  lsu_mem_stage #(.XLEN(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .ex_mem_in(ex_mem_in), .stall(stall), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_busy(mem_busy),
    .mem_wb_out(mem_wb_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_mem_t mk_mem(input logic rd_en, input logic wr_en, input mem_size_e sz,
                                     input logic uns, input logic [63:0] addr,
                                     input logic [63:0] rs2, input logic [4:0] rd);
    ex_mem_t o;
    o = '0;
    o.ctrl.reg_write    = rd_en;
    o.ctrl.mem_to_reg   = rd_en;
    o.ctrl.mem_read     = rd_en;
    o.ctrl.mem_write    = wr_en;
    o.ctrl.mem_size     = sz;
    o.ctrl.mem_unsigned = uns;
    o.rd         = rd;
    o.alu_result = addr;
    o.rs2_data   = rs2;
    return o;
  endfunction

  function automatic ex_mem_t mk_alu(input logic [4:0] rd, input logic [63:0] val);
    ex_mem_t o;
    o = '0;
    o.ctrl.reg_write = 1'b1;
    o.rd             = rd;
    o.alu_result     = val;
    return o;
  endfunction

  // Handshake driver: grant after gnt_dly cycles, rvalid rv_dly cycles after the cycle following grant
  task automatic run_txn(input int gnt_dly, input int rv_dly, input logic [31:0] rdat,
                         input logic [31:0] exp_addr, output int b_n, output int r_n);
    int g_at;
    bit fin;
    g_at = -1; b_n = 0; r_n = 0; fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      dmem_gnt    = (g_at < 0) && (c >= gnt_dly);
      dmem_rvalid = (g_at >= 0) && (c == g_at + 1 + rv_dly);
      dmem_rdata  = dmem_rvalid ? rdat : 32'h0;
      #1;
      if (dmem_req) begin
        r_n++;
        check_eq("req_addr_stable", dmem_addr, exp_addr);
      end
      if (dmem_gnt && dmem_req) g_at = c;
      if (mem_busy) b_n++;
      else fin = 1'b1;
      tick();
    end
    check_eq("txn_bound", fin, 1'b1);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_W, 1'b0, 64'h100, 64'h0, 5'd1);
    #1;
    check_eq("rst_req", dmem_req, 1'b0);
    check_eq("rst_wb_alu", mem_wb_out.alu_result, 64'h0);
    check_eq("rst_wb_exc", mem_wb_out.exc_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Non-memory op: zero added latency
    ex_mem_in = mk_alu(5'd7, 64'h1234);
    #1;
    check_eq("alu_busy", mem_busy, 1'b0);
    check_eq("alu_req", dmem_req, 1'b0);
    tick();
    check_eq("alu_wb_val", mem_wb_out.alu_result, 64'h1234);
    check_eq("alu_wb_rd", mem_wb_out.rd, 5'd7);

    // LB 0x103, sign-extend 0x80
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_B, 1'b0, 64'h103, 64'h0, 5'd3);
    #1;
    check_eq("lb_req", dmem_req, 1'b1);
    check_eq("lb_we", dmem_we, 1'b0);
    run_txn(0, 0, 32'h80123456, 32'h100, busy_n, req_n);
    check_eq("lb_busy_cycles", busy_n, 1);
    check_eq("lb_req_cycles", req_n, 1);
    check_eq("lb_data", mem_wb_out.mem_data, 64'hFFFFFF80);
    check_eq("lb_exc", mem_wb_out.exc_valid, 1'b0);
    ex_mem_in = mk_alu(5'd0, 64'h0);

    // SH 0x102 lane replication and strobes
    ex_mem_in = mk_mem(1'b0, 1'b1, SIZE_H, 1'b0, 64'h102, 64'h1234ABCD, 5'd0);
    #1;
    check_eq("sh_wdata", dmem_wdata, 32'hABCDABCD);
    check_eq("sh_wstrb", dmem_wstrb, 4'b1100);
    check_eq("sh_we", dmem_we, 1'b1);
    run_txn(0, 0, 32'h0, 32'h100, busy_n, req_n);
    check_eq("sh_exc", mem_wb_out.exc_valid, 1'b0);

    // SB 0x1
    ex_mem_in = mk_mem(1'b0, 1'b1, SIZE_B, 1'b0, 64'h1, 64'h55, 5'd0);
    #1;
    check_eq("sb_wdata", dmem_wdata, 32'h55555555);
    check_eq("sb_wstrb", dmem_wstrb, 4'b0010);
    run_txn(0, 0, 32'h0, 32'h0, busy_n, req_n);

    // Misaligned LW, SW and D on 32-bit datapath
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_W, 1'b0, 64'h101, 64'h0, 5'd4);
    #1;
    check_eq("lwmis_req", dmem_req, 1'b0);
    check_eq("lwmis_busy", mem_busy, 1'b0);
    tick();
    check_eq("lwmis_exc", mem_wb_out.exc_valid, 1'b1);
    check_eq("lwmis_cause", mem_wb_out.exc_cause, LOAD_MISALIGNED);
    check_eq("lwmis_rw", mem_wb_out.ctrl.reg_write, 1'b0);
    ex_mem_in = mk_mem(1'b0, 1'b1, SIZE_W, 1'b0, 64'h102, 64'h0, 5'd0);
    #1;
    check_eq("swmis_req", dmem_req, 1'b0);
    tick();
    check_eq("swmis_cause", mem_wb_out.exc_cause, STORE_MISALIGNED);
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_D, 1'b0, 64'h100, 64'h0, 5'd4);
    #1;
    check_eq("ld32_req", dmem_req, 1'b0);
    tick();
    check_eq("ld32_cause", mem_wb_out.exc_cause, LOAD_MISALIGNED);

    // LHU 0x2 with grant delayed 3 cycles
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_H, 1'b1, 64'h2, 64'h0, 5'd6);
    run_txn(3, 0, 32'hBEEF0000, 32'h0, busy_n, req_n);
    check_eq("lhu_busy_cycles", busy_n, 4);
    check_eq("lhu_req_cycles", req_n, 4);
    check_eq("lhu_data", mem_wb_out.mem_data, 64'h0000BEEF);
    check_eq("lhu_rd", mem_wb_out.rd, 5'd6);

    // Timeout with no rvalid, then a late rvalid
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_W, 1'b0, 64'h200, 64'h0, 5'd8);
    run_txn(0, 1000, 32'h0, 32'h200, busy_n, req_n);
    check_eq("to_busy_cycles", busy_n, 64);
    check_eq("to_exc", mem_wb_out.exc_valid, 1'b1);
    check_eq("to_cause", mem_wb_out.exc_cause, LOAD_ACCESS_FAULT);
    check_eq("to_rw", mem_wb_out.ctrl.reg_write, 1'b0);
    ex_mem_in = mk_alu(5'd2, 64'h77);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    check_eq("late_busy", mem_busy, 1'b0);
    check_eq("late_req", dmem_req, 1'b0);
    tick();
    dmem_rvalid = 1'b0;
    check_eq("late_wb_alu", mem_wb_out.alu_result, 64'h77);
    check_eq("late_wb_data", mem_wb_out.mem_data, 64'h0);
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_W, 1'b0, 64'h300, 64'h0, 5'd9);
    run_txn(0, 0, 32'h11223344, 32'h300, busy_n, req_n);
    check_eq("after_to_data", mem_wb_out.mem_data, 64'h11223344);

    // Flush during RESP: transaction completes, bubble written
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_W, 1'b0, 64'h400, 64'h0, 5'd10);
    dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_gnt = 1'b0; flush = 1'b1;
    #1;
    check_eq("fl_busy", mem_busy, 1'b1);
    tick();
    flush = 1'b0;
    check_eq("fl_wb_alu", mem_wb_out.alu_result, 64'h0);
    check_eq("fl_wb_rw", mem_wb_out.ctrl.reg_write, 1'b0);
    #1;
    check_eq("fl_still_busy", mem_busy, 1'b1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    check_eq("fl_done_busy", mem_busy, 1'b0);
    tick();
    dmem_rvalid = 1'b0;
    check_eq("fl_discard_data", mem_wb_out.mem_data, 64'h0);
    check_eq("fl_discard_rd", mem_wb_out.rd, 5'd0);
    ex_mem_in = mk_alu(5'd2, 64'h77);
    tick();

    // Stall in the rvalid cycle: data held, no re-request
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_W, 1'b0, 64'h500, 64'h0, 5'd11);
    dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D; stall = 1'b1;
    #1;
    check_eq("st_rv_busy", mem_busy, 1'b0);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_eq("st_no_rereq", dmem_req, 1'b0);
      check_eq("st_wb_held", mem_wb_out.alu_result, 64'h77);
      tick();
    end
    stall = 1'b0;
    #1;
    check_eq("st_release_req", dmem_req, 1'b0);
    tick();
    check_eq("st_data", mem_wb_out.mem_data, 64'hCAFEF00D);
    check_eq("st_rd", mem_wb_out.rd, 5'd11);
    ex_mem_in = mk_alu(5'd2, 64'h88);
    tick();

    // Reset mid-transaction: later rvalid ignored
    ex_mem_in = mk_mem(1'b1, 1'b0, SIZE_W, 1'b0, 64'h600, 64'h0, 5'd12);
    dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_gnt = 1'b0; rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", dmem_req, 1'b0);
    check_eq("mid_rst_wb", mem_wb_out.alu_result, 64'h0);
    tick();
    rst_n = 1'b1;
    ex_mem_in = mk_alu(5'd13, 64'h99);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5A5A5A5A;
    #1;
    check_eq("mid_rst_busy", mem_busy, 1'b0);
    tick();
    dmem_rvalid = 1'b0;
    check_eq("mid_rst_wb_data", mem_wb_out.mem_data, 64'h0);
    check_eq("mid_rst_wb_alu", mem_wb_out.alu_result, 64'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
